// File: rtl/goose_game_ctrl.sv
// goose_game_ctrl
//   Top-level sequencer for the goose-run VGA game. It owns the
//   attract/play/game-over state machine, the per-frame goose/bean
//   collision latch, the running score and the best score since reset.
//
// Ports
//   clk        pixel-domain clock
//   reset      asynchronous, active-low reset
//   btn_l/r    raw asynchronous buttons
//   frame_end  one-clk pulse at the start of vertical blanking
//   goose_px   current pixel belongs to the goose sprite
//   bean_px    current pixel belongs to the bean sprite
//   state      00 ATTRACT, 01 PLAY, 10 DEAD
//   play       high in PLAY (animation enable)
//   hit        high in DEAD (collision latched)
//   restart    one-clk pulse on every entry to PLAY
//   score      current run score
//   score_hi   best score since reset
//
// Optional feature: define SCORE_BCD_EN to count score/score_hi in packed
// BCD (SCORE_W/4 digits, saturating at all-9s). Default is plain binary.

module goose_game_ctrl #(
  parameter int SCORE_W   = 16,
  parameter int TICK_DIV  = 10,
  parameter int DEAD_HOLD = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               frame_end,
  input  logic               goose_px,
  input  logic               bean_px,
  output logic [1:0]         state,
  output logic               play,
  output logic               hit,
  output logic               restart,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] score_hi
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(DEAD_HOLD);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'b00,
    ST_PLAY    = 2'b01,
    ST_DEAD    = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [1:0]          r_syncL;
  logic [1:0]          r_syncR;
  logic                r_btnAnyD;
  logic                r_press;
  logic                r_coll;
  logic                r_restart;
  logic [TICK_W-1:0]   r_tickCnt;
  logic [HOLD_W-1:0]   r_holdCnt;
  logic [SCORE_W-1:0]  r_score;
  logic [SCORE_W-1:0]  r_scoreHi;

  logic w_btnAny;
  logic w_hitNow;
  logic w_enterPlay;
  logic w_enterDead;
  logic w_tickFrame;
  logic w_holdFrame;

`ifdef SCORE_BCD_EN
  localparam int DIGITS = SCORE_W / 4;

  // Packed-BCD increment with per-digit carry; holds once every digit is 9.
  function automatic logic [SCORE_W-1:0] incScore(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] res;
    logic               carry;
    logic               allNine;
    logic [3:0]         d;
    res     = v;
    carry   = 1'b1;
    allNine = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) allNine = 1'b0;
    end
    if (!allNine) begin
      for (int i = 0; i < DIGITS; i++) begin
        d = v[4*i +: 4];
        if (carry) begin
          if (d == 4'd9) begin
            d     = 4'd0;
            carry = 1'b1;
          end else begin
            d     = d + 4'd1;
            carry = 1'b0;
          end
        end
        res[4*i +: 4] = d;
      end
    end
    return res;
  endfunction
`else
  // Binary increment that saturates at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] incScore(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction
`endif

  assign w_btnAny = r_syncL[1] | r_syncR[1];
  assign w_hitNow = goose_px & bean_px;

  // Two-flop synchronizers followed by a registered rising-edge detect, so a
  // press pulse appears three clocks after the raw button rises and a held
  // button can never produce a second pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_syncL   <= 2'b00;
      r_syncR   <= 2'b00;
      r_btnAnyD <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_syncL   <= {r_syncL[0], btn_l};
      r_syncR   <= {r_syncR[0], btn_r};
      r_btnAnyD <= w_btnAny;
      r_press   <= w_btnAny & ~r_btnAnyD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_ATTRACT;
    else        r_state <= w_stateNext;
  end

  // Next-state logic. A press that causes a transition swallows any
  // coincident frame_end; a collision in the frame_end clock itself still
  // counts toward the ending frame.
  always_comb begin
    w_stateNext = r_state;
    w_enterPlay = 1'b0;
    w_enterDead = 1'b0;
    w_tickFrame = 1'b0;
    w_holdFrame = 1'b0;
    case (r_state)
      ST_ATTRACT: begin
        if (r_press) begin
          w_stateNext = ST_PLAY;
          w_enterPlay = 1'b1;
        end
      end
      ST_PLAY: begin
        if (frame_end) begin
          if (r_coll | w_hitNow) begin
            w_stateNext = ST_DEAD;
            w_enterDead = 1'b1;
          end else begin
            w_tickFrame = 1'b1;
          end
        end
      end
      ST_DEAD: begin
        if (r_press && (r_holdCnt == HOLD_MAX)) begin
          w_stateNext = ST_PLAY;
          w_enterPlay = 1'b1;
        end else if (frame_end) begin
          w_holdFrame = 1'b1;
        end
      end
      default: w_stateNext = ST_ATTRACT;
    endcase
  end

  // Datapath: collision latch, frame counters, score and high score.
  // The collision latch only lives within PLAY and is emptied each frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_coll    <= 1'b0;
      r_restart <= 1'b0;
      r_tickCnt <= '0;
      r_holdCnt <= '0;
      r_score   <= '0;
      r_scoreHi <= '0;
    end else begin
      r_coll    <= (r_state == ST_PLAY) && !frame_end && (r_coll | w_hitNow);
      r_restart <= w_enterPlay;
      if (w_enterPlay) begin
        r_tickCnt <= '0;
        r_holdCnt <= '0;
        r_score   <= '0;
      end else begin
        if (w_tickFrame) begin
          if (r_tickCnt == TICK_LAST) begin
            r_tickCnt <= '0;
            r_score   <= incScore(r_score);
          end else begin
            r_tickCnt <= r_tickCnt + TICK_W'(1);
          end
        end
        if (w_holdFrame && (r_holdCnt != HOLD_MAX)) begin
          r_holdCnt <= r_holdCnt + HOLD_W'(1);
        end
      end
      if (w_enterDead && (r_score > r_scoreHi)) begin
        r_scoreHi <= r_score;
      end
    end
  end

  assign state    = r_state;
  assign play     = (r_state == ST_PLAY);
  assign hit      = (r_state == ST_DEAD);
  assign restart  = r_restart;
  assign score    = r_score;
  assign score_hi = r_scoreHi;

endmodule

// File: doc/goose_game_ctrl.md
Name: goose_game_ctrl

Overview:
- Top-level game sequencer for the goose-run VGA game. Owns the attract/play/game-over state machine, the running score and the high score.
- Detects goose/bean pixel collisions per frame and gates animation and scoring.
- Sits between the button inputs, the pixel classifiers and the draw/animation blocks; replaces ad-hoc hit/play flags in the top level.

Parameters:
- SCORE_W, 16, width of score and score_hi outputs.
- TICK_DIV, 10, frame_end pulses per score increment (60 Hz frames -> 6 points/s).
- DEAD_HOLD, 30, frames the game-over screen ignores buttons before restart is allowed.

Ports:
- clk  in  1  system pixel-domain clock.
- reset  in  1  asynchronous, active-low reset.
- btn_l  in  1  raw left button (JA[2]), asynchronous.
- btn_r  in  1  raw right button (JA[3]), asynchronous.
- frame_end  in  1  one-clk pulse at the start of vertical blanking, once per frame.
- goose_px  in  1  current pixel belongs to goose sprite.
- bean_px  in  1  current pixel belongs to bean sprite.
- state  out  2  00 ATTRACT, 01 PLAY, 10 DEAD.
- play  out  1  high in PLAY; animation enable for goose/bean movers.
- hit  out  1  high in DEAD (collision latched).
- restart  out  1  one-clk pulse on every entry to PLAY; resets sprite positions.
- score  out  SCORE_W  current run score.
- score_hi  out  SCORE_W  best score since reset.

Behaviour:
- Reset (reset low, async): state=ATTRACT; play=0, hit=0, restart=0, score=0, score_hi=0, all internal counters 0. Outputs remain at reset values until the first clk edge after deassertion.
- Buttons: each passes a 2-flop synchronizer. btn_any = sync_l | sync_r. press = rising edge of btn_any, a one-clk pulse. Latency is 3 clk from raw input to press.
- Collision: coll_flag sets on any clk with goose_px & bean_px while state==PLAY.
  - Evaluated and cleared on frame_end.
  - A coincidence in the same clk as frame_end counts toward the current frame.
- ATTRACT:
  - press -> PLAY next clk. Set score=0, pulse restart, clear coll_flag and tick_cnt.
- PLAY:
  - On each frame_end, tick_cnt increments. When tick_cnt==TICK_DIV-1 it wraps to 0 and score increments. score saturates at all-ones with no wrap.
  - On frame_end with coll_flag=1 -> DEAD. The score increment for that frame is suppressed.
  - When entering DEAD, if score>score_hi, then score_hi<=score, registered in the same clk as the transition.
  - Buttons are ignored for state transitions; they are still synchronized for the sprite blocks.
- DEAD:
  - score and score_hi are frozen. hold_cnt counts frame_end pulses, saturating at DEAD_HOLD.
  - press with hold_cnt==DEAD_HOLD -> PLAY. Same entry actions as from ATTRACT: score=0, restart pulse, hold_cnt=0.
  - press before the hold expires is discarded. A held button does not retrigger; a new rising edge is required.
- restart: exactly one clk high per entry to PLAY, never asserted in reset.
- Simultaneous events:
  - If press and frame_end coincide in ATTRACT/DEAD, the transition wins and the frame_end is not counted.
  - If reset is asserted mid-frame, coll_flag is discarded.
- score_hi compare is unsigned, full SCORE_W width.

Optional Feature:
- Macro SCORE_BCD_EN.
- When defined:
  - score and score_hi are packed BCD, SCORE_W/4 digits. SCORE_W must be a multiple of 4.
  - Increment is BCD with per-digit carry: 0x0099 -> 0x0100.
  - Saturation is at all-9s.
  - The high-score compare is unsigned, which is valid for packed BCD.
- When undefined: plain binary counting and saturation as above.

Test Plan:
1. Reset low mid-PLAY, then release -> state=00, score=0, score_hi=0, play=0, no restart pulse.
2. From ATTRACT, pulse btn_l for 5 clk -> press after 3 clk, state=01 next clk, a single restart pulse. Then 25 frame_end with TICK_DIV=10 -> score=2.
3. In PLAY, score=7: assert goose_px&bean_px for 1 clk, then frame_end -> state=10, hit=1, score stays 7, score_hi=7. A second run ending at score 3 -> score_hi stays 7.
4. In DEAD, press after 10 frames with DEAD_HOLD=30 -> ignored. Hold btn_r through 30 frames -> no restart. Release and press again -> PLAY, score=0, restart pulse.
5. Collision coincident with the frame_end clk -> DEAD on that frame. Collision in ATTRACT -> no effect.
6. Score=0xFFFE (binary) over 2 ticks -> 0xFFFF and holds. With SCORE_BCD_EN, 0x0099 + 1 tick -> 0x0100, and 0x9999 holds.
